// File: rtl/plab1_imul_mul_arbiter_pkg.sv
// Shared message definitions for the two-port multiplier arbiter: request
// message layout, product width and the grant tag carried in the tag queue.
`ifndef PLAB1_IMUL_MULDIV_REQ_MSG_NBITS
`define PLAB1_IMUL_MULDIV_REQ_MSG_NBITS 67
`endif
`ifndef PLAB1_IMUL_ARB_TAG_NBITS
`define PLAB1_IMUL_ARB_TAG_NBITS 1
`endif

package plab1_imul_mul_arbiter_pkg;

    localparam int unsigned REQ_MSG_NBITS  = `PLAB1_IMUL_MULDIV_REQ_MSG_NBITS;
    localparam int unsigned ARB_TAG_NBITS  = `PLAB1_IMUL_ARB_TAG_NBITS;
    localparam int unsigned RESP_MSG_NBITS = 32;
    localparam int unsigned STAT_NBITS     = 16;

    typedef enum logic [2:0] {
        MULDIV_MUL  = 3'd0,
        MULDIV_DIV  = 3'd1,
        MULDIV_DIVU = 3'd2,
        MULDIV_REM  = 3'd3,
        MULDIV_REMU = 3'd4
    } muldiv_func_e;

    typedef struct packed {
        muldiv_func_e func;
        logic [31:0]  a;
        logic [31:0]  b;
    } muldiv_req_msg_t;

    typedef logic [ARB_TAG_NBITS-1:0] arb_tag_t;

endpackage

// File: rtl/plab1_imul_mul_arbiter_if.sv
// Client-side and multiplier-side val/rdy channels of the arbiter.
interface plab1_imul_mul_arbiter_if;
    import plab1_imul_mul_arbiter_pkg::*;

    logic                       in0_val;
    logic                       in0_rdy;
    muldiv_req_msg_t            in0_msg;
    logic                       in1_val;
    logic                       in1_rdy;
    muldiv_req_msg_t            in1_msg;

    logic                       out0_val;
    logic                       out0_rdy;
    logic [RESP_MSG_NBITS-1:0]  out0_msg;
    logic                       out1_val;
    logic                       out1_rdy;
    logic [RESP_MSG_NBITS-1:0]  out1_msg;

    logic                       mul_req_val;
    logic                       mul_req_rdy;
    muldiv_req_msg_t            mul_req_msg;
    logic                       mul_resp_val;
    logic                       mul_resp_rdy;
    logic [RESP_MSG_NBITS-1:0]  mul_resp_msg;

    // Arbiter side
    modport slave (
        input  in0_val, in0_msg, in1_val, in1_msg,
        input  out0_rdy, out1_rdy,
        input  mul_req_rdy, mul_resp_val, mul_resp_msg,
        output in0_rdy, in1_rdy,
        output out0_val, out0_msg, out1_val, out1_msg,
        output mul_req_val, mul_req_msg, mul_resp_rdy
    );

    // Environment side: clients plus the multiplier
    modport master (
        output in0_val, in0_msg, in1_val, in1_msg,
        output out0_rdy, out1_rdy,
        output mul_req_rdy, mul_resp_val, mul_resp_msg,
        input  in0_rdy, in1_rdy,
        input  out0_val, out0_msg, out1_val, out1_msg,
        input  mul_req_val, mul_req_msg, mul_resp_rdy
    );

endinterface

// File: rtl/plab1_imul_tag_queue.sv
// In-order FIFO of grant tags; depth must be a power of two so the
// pointers wrap naturally. Full/empty come from a registered count.
module plab1_imul_tag_queue
    import plab1_imul_mul_arbiter_pkg::*;
#(
    parameter int unsigned p_depth = 4
)(
    input  logic     clk,
    input  logic     reset,
    input  logic     enq_val,
    output logic     enq_rdy,
    input  arb_tag_t enq_msg,
    output logic     deq_val,
    input  logic     deq_rdy,
    output arb_tag_t deq_msg
);

    localparam int unsigned PTR_W = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int unsigned CNT_W = $clog2(p_depth + 1);

    arb_tag_t           mem [p_depth];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;
    logic               enq_fire;
    logic               deq_fire;

    assign enq_rdy  = (count != CNT_W'(p_depth));
    assign deq_val  = (count != '0);
    assign deq_msg  = mem[head];
    assign enq_fire = enq_val && enq_rdy;
    assign deq_fire = deq_rdy && deq_val;

    always_ff @(posedge clk) begin
        if (enq_fire) mem[tail] <= enq_msg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq_fire) tail <= tail + PTR_W'(1);
            if (deq_fire) head <= head + PTR_W'(1);
            if (enq_fire && !deq_fire)      count <= count + CNT_W'(1);
            else if (deq_fire && !enq_fire) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/plab1_imul_mul_arbiter.sv
// Round-robin sharing of one multiplier between two requesters, with
// in-order response steering. Grant counters exist only when
// PLAB1_IMUL_MUL_ARBITER_STATS_EN is defined.
module plab1_imul_mul_arbiter
    import plab1_imul_mul_arbiter_pkg::*;
#(
    parameter int unsigned p_max_outstanding = 4
)(
    input  logic                    clk,
    input  logic                    reset,
    plab1_imul_mul_arbiter_if.slave bus,
    output logic [STAT_NBITS-1:0]   stat_grants0,
    output logic [STAT_NBITS-1:0]   stat_grants1
);

    logic     prio;
    logic     grant;
    logic     can_issue;
    logic     req_xfer;
    logic     resp_xfer;
    logic     resp_ok;
    logic     head_rdy;
    logic     q_enq_rdy;
    logic     q_deq_val;
    arb_tag_t head;

    plab1_imul_tag_queue #(.p_depth(p_max_outstanding)) tag_q (
        .clk     (clk),
        .reset   (reset),
        .enq_val (req_xfer),
        .enq_rdy (q_enq_rdy),
        .enq_msg (arb_tag_t'(grant)),
        .deq_val (q_deq_val),
        .deq_rdy (resp_xfer),
        .deq_msg (head)
    );

    // Request grant and response steering; everything is gated off in reset
    always_comb begin
        grant = 1'b0;
        if (bus.in0_val && bus.in1_val) grant = prio;
        else if (bus.in1_val)           grant = 1'b1;

        can_issue       = !reset && bus.mul_req_rdy && q_enq_rdy;
        bus.mul_req_val = can_issue && (bus.in0_val || bus.in1_val);
        bus.mul_req_msg = grant ? bus.in1_msg : bus.in0_msg;
        bus.in0_rdy     = can_issue && !grant;
        bus.in1_rdy     = can_issue && grant;
        req_xfer        = bus.mul_req_val && bus.mul_req_rdy;

        resp_ok          = !reset && q_deq_val;
        head_rdy         = (head == arb_tag_t'(1)) ? bus.out1_rdy : bus.out0_rdy;
        bus.out0_val     = resp_ok && bus.mul_resp_val && (head == arb_tag_t'(0));
        bus.out1_val     = resp_ok && bus.mul_resp_val && (head == arb_tag_t'(1));
        bus.out0_msg     = bus.mul_resp_msg;
        bus.out1_msg     = bus.mul_resp_msg;
        bus.mul_resp_rdy = resp_ok && head_rdy;
        resp_xfer        = bus.mul_resp_val && bus.mul_resp_rdy;
    end

    // The requester just served drops to low priority
    always_ff @(posedge clk) begin
        if (reset)         prio <= 1'b0;
        else if (req_xfer) prio <= ~grant;
    end

`ifdef PLAB1_IMUL_MUL_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_grants0 <= '0;
            stat_grants1 <= '0;
        end else if (req_xfer) begin
            if (grant) stat_grants1 <= stat_grants1 + STAT_NBITS'(1);
            else       stat_grants0 <= stat_grants0 + STAT_NBITS'(1);
        end
    end
`else
    assign stat_grants0 = '0;
    assign stat_grants1 = '0;
`endif

    // Protocol sanity outside reset
    always @(posedge clk) begin
        if (!reset) begin
            assert (!$isunknown({bus.in0_val, bus.in1_val, bus.out0_rdy, bus.out1_rdy,
                                 bus.mul_req_rdy, bus.mul_resp_val}))
                else $error("arbiter: X on a control input");
            assert (!(bus.in0_rdy && bus.in1_rdy))
                else $error("arbiter: both requesters ready");
            assert (!(bus.mul_resp_val && !q_deq_val))
                else $error("arbiter: unexpected multiplier response with no outstanding tag");
        end
    end

endmodule

// File: tb/tb_plab1_imul_mul_arbiter.sv
// Randomized bench for plab1_imul_mul_arbiter with a queue-based reference
// model; honours PLAB1_IMUL_MUL_ARBITER_STATS_EN for the grant counters.
module tb_plab1_imul_mul_arbiter;
    import plab1_imul_mul_arbiter_pkg::*;

    localparam int unsigned MAXO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] stat_grants0;
    logic [15:0] stat_grants1;

    plab1_imul_mul_arbiter_if bus ();

    plab1_imul_mul_arbiter #(.p_max_outstanding(MAXO)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .stat_grants0 (stat_grants0),
        .stat_grants1 (stat_grants1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_prio;
    bit          m_tags[$];
    logic [31:0] m_exp0[$];
    logic [31:0] m_exp1[$];
    logic [15:0] m_st[2];
    logic [31:0] mulq[$];

    // Stimulus knobs and requester hold registers
    bit              rst_knob;
    int              pv[2], budget[2], pordy[2];
    int              prdy, prval;
    bit              fix[2];
    logic [31:0]     fa[2], fb[2];
    bit              hv[2];
    muldiv_req_msg_t hm[2];

    // Observation logs
    bit          grant_log[$];
    logic [31:0] deliv0[$];
    logic [31:0] deliv1[$];
    int          out_seen[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_msg(input string name, input muldiv_req_msg_t act, input muldiv_req_msg_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] prod(input muldiv_req_msg_t m);
        return m.a * m.b;
    endfunction

    task automatic clear_logs();
        grant_log.delete();
        deliv0.delete();
        deliv1.delete();
        out_seen[0] = 0;
        out_seen[1] = 0;
    endtask

    task automatic cycle();
        bit mrdy, rval, full, can, g, any, ne, h, exp_rv, exp_rrdy, req_f, resp_f;
        bit ordy[2], exp_rdy[2], exp_ov[2];
        logic [31:0] eh;
        bit tg;
        @(negedge clk);
        reset = rst_knob;
        for (int k = 0; k < 2; k++) begin
            if (!hv[k] && budget[k] != 0 && $urandom_range(99) < 32'(pv[k])) begin
                hv[k]      = 1'b1;
                hm[k].func = MULDIV_MUL;
                hm[k].a    = fix[k] ? fa[k] : $urandom();
                hm[k].b    = fix[k] ? fb[k] : $urandom();
            end
            ordy[k] = ($urandom_range(99) < 32'(pordy[k]));
        end
        mrdy = ($urandom_range(99) < 32'(prdy));
        rval = (mulq.size() > 0) && ($urandom_range(99) < 32'(prval));
        bus.in0_val      = hv[0];
        bus.in0_msg      = hm[0];
        bus.in1_val      = hv[1];
        bus.in1_msg      = hm[1];
        bus.mul_req_rdy  = mrdy;
        bus.mul_resp_val = rval;
        bus.mul_resp_msg = rval ? mulq[0] : $urandom();
        bus.out0_rdy     = ordy[0];
        bus.out1_rdy     = ordy[1];
        #1;
        full       = (m_tags.size() == MAXO);
        can        = !reset && mrdy && !full;
        any        = hv[0] || hv[1];
        g          = (hv[0] && hv[1]) ? m_prio : hv[1];
        exp_rv     = can && any;
        exp_rdy[0] = can && !g;
        exp_rdy[1] = can && g;
        ne         = !reset && (m_tags.size() > 0);
        h          = ne ? m_tags[0] : 1'b0;
        exp_ov[0]  = rval && ne && !h;
        exp_ov[1]  = rval && ne && h;
        exp_rrdy   = ne && ordy[h];

        check("in0_rdy", 64'(bus.in0_rdy), 64'(exp_rdy[0]));
        check("in1_rdy", 64'(bus.in1_rdy), 64'(exp_rdy[1]));
        check("mul_req_val", 64'(bus.mul_req_val), 64'(exp_rv));
        if (exp_rv) check_msg("mul_req_msg", bus.mul_req_msg, hm[g]);
        check("out0_val", 64'(bus.out0_val), 64'(exp_ov[0]));
        check("out1_val", 64'(bus.out1_val), 64'(exp_ov[1]));
        check("mul_resp_rdy", 64'(bus.mul_resp_rdy), 64'(exp_rrdy));
        if (exp_ov[0]) begin
            eh = (m_exp0.size() > 0) ? m_exp0[0] : 32'hDEAD_0000;
            check("out0_msg", 64'(bus.out0_msg), 64'(eh));
        end
        if (exp_ov[1]) begin
            eh = (m_exp1.size() > 0) ? m_exp1[0] : 32'hDEAD_0001;
            check("out1_msg", 64'(bus.out1_msg), 64'(eh));
        end
`ifdef PLAB1_IMUL_MUL_ARBITER_STATS_EN
        check("stat_grants0", 64'(stat_grants0), 64'(m_st[0]));
        check("stat_grants1", 64'(stat_grants1), 64'(m_st[1]));
`else
        check("stat_grants0", 64'(stat_grants0), 64'(16'd0));
        check("stat_grants1", 64'(stat_grants1), 64'(16'd0));
`endif
        if (bus.out0_val === 1'b1) out_seen[0]++;
        if (bus.out1_val === 1'b1) out_seen[1]++;
        req_f  = exp_rv;
        resp_f = rval && exp_rrdy;

        @(posedge clk);
        if (reset) begin
            m_tags.delete();
            m_exp0.delete();
            m_exp1.delete();
            mulq.delete();
            m_prio = 1'b0;
            m_st[0] = 16'd0;
            m_st[1] = 16'd0;
            hv[0] = 1'b0;
            hv[1] = 1'b0;
        end else begin
            if (resp_f) begin
                void'(mulq.pop_front());
                tg = m_tags.pop_front();
                if (tg) deliv1.push_back(m_exp1.pop_front());
                else    deliv0.push_back(m_exp0.pop_front());
            end
            if (req_f) begin
                m_tags.push_back(g);
                mulq.push_back(prod(hm[g]));
                if (g) m_exp1.push_back(prod(hm[g]));
                else   m_exp0.push_back(prod(hm[g]));
                m_prio = !g;
                m_st[g] = m_st[g] + 16'd1;
                grant_log.push_back(g);
                hv[g] = 1'b0;
                if (budget[g] > 0) budget[g]--;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset(input int n);
        rst_knob = 1'b1;
        run(n);
        rst_knob = 1'b0;
        clear_logs();
    endtask

    task automatic knobs(input int v0, input int v1, input int b0, input int b1,
                         input int rdy, input int rv, input int or0, input int or1);
        pv[0] = v0; pv[1] = v1; budget[0] = b0; budget[1] = b1;
        prdy = rdy; prval = rv; pordy[0] = or0; pordy[1] = or1;
        fix[0] = 1'b0; fix[1] = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        rst_knob = 1'b1;
        bus.in0_val = 1'b0; bus.in1_val = 1'b0;
        bus.in0_msg = '0;   bus.in1_msg = '0;
        bus.out0_rdy = 1'b0; bus.out1_rdy = 1'b0;
        bus.mul_req_rdy = 1'b0; bus.mul_resp_val = 1'b0; bus.mul_resp_msg = '0;
        m_prio = 1'b0; m_st[0] = 16'd0; m_st[1] = 16'd0;
        hv[0] = 1'b0; hv[1] = 1'b0;
        hm[0] = '0; hm[1] = '0;
        fa[0] = '0; fa[1] = '0; fb[0] = '0; fb[1] = '0;
        knobs(0, 0, 0, 0, 100, 100, 100, 100);
        do_reset(2);

        // Single request 3*4 from requester 0
        knobs(100, 0, 1, 0, 100, 100, 100, 100);
        fix[0] = 1'b1; fa[0] = 32'd3; fb[0] = 32'd4;
        run(10);
        check("p1_resp_count", 64'(deliv0.size()), 64'd1);
        check("p1_product", 64'(deliv0[0]), 64'd12);
        check("p1_out1_never", 64'(out_seen[1]), 64'd0);

        // Both requesters always valid: alternating grants
        do_reset(1);
        knobs(100, 100, 4, 4, 100, 100, 100, 100);
        fix[0] = 1'b1; fa[0] = 32'd2; fb[0] = 32'd5;
        fix[1] = 1'b1; fa[1] = 32'd7; fb[1] = 32'd6;
        run(20);
        check("p2_grants", 64'(grant_log.size()), 64'd8);
        for (int i = 0; i < 8; i++) check("p2_grant_order", 64'(grant_log[i]), 64'(i % 2));
        check("p2_resp0_count", 64'(deliv0.size()), 64'd4);
        check("p2_resp1_count", 64'(deliv1.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("p2_resp0", 64'(deliv0[i]), 64'd10);
            check("p2_resp1", 64'(deliv1[i]), 64'd42);
        end
`ifdef PLAB1_IMUL_MUL_ARBITER_STATS_EN
        check("p2_stat0", 64'(stat_grants0), 64'd4);
        check("p2_stat1", 64'(stat_grants1), 64'd4);
`else
        check("p2_stat0", 64'(stat_grants0), 64'd0);
        check("p2_stat1", 64'(stat_grants1), 64'd0);
`endif

        // Tag queue fills at four outstanding; a dequeue does not bypass
        do_reset(1);
        knobs(100, 0, 5, 0, 100, 0, 100, 100);
        run(8);
        check("p3_grants_full", 64'(grant_log.size()), 64'd4);
        prval = 100;
        run(1);
        check("p3_no_bypass", 64'(grant_log.size()), 64'd4);
        check("p3_first_resp", 64'(deliv0.size()), 64'd1);
        run(10);
        check("p3_grants_all", 64'(grant_log.size()), 64'd5);
        check("p3_resp_all", 64'(deliv0.size()), 64'd5);

        // Head tag 1 blocks on out1_rdy even when out0 is ready
        do_reset(1);
        knobs(0, 100, 0, 1, 100, 0, 100, 100);
        run(3);
        prval = 100; pordy[1] = 0;
        run(5);
        check("p4_blocked", 64'(deliv1.size()), 64'd0);
        check("p4_out0_quiet", 64'(out_seen[0]), 64'd0);
        pordy[1] = 100;
        run(2);
        check("p4_delivered", 64'(deliv1.size()), 64'd1);

        // Reset with three outstanding, then a fresh wrap-around product
        do_reset(1);
        knobs(100, 0, 3, 0, 100, 0, 100, 100);
        run(6);
        check("p5_outstanding", 64'(grant_log.size()), 64'd3);
        do_reset(1);
        knobs(0, 100, 0, 1, 100, 100, 100, 100);
        fix[1] = 1'b1; fa[1] = 32'hFFFF_FFFF; fb[1] = 32'd2;
        run(6);
        check("p5_resp_count", 64'(deliv1.size()), 64'd1);
        check("p5_product", 64'(deliv1[0]), 64'hFFFF_FFFE);
        check("p5_out0_none", 64'(deliv0.size()), 64'd0);

        // Randomized traffic with occasional mid-stream resets
        for (int blk = 0; blk < 15; blk++) begin
            knobs(int'($urandom_range(100)), int'($urandom_range(100)), -1, -1,
                  int'($urandom_range(20, 100)), int'($urandom_range(20, 100)),
                  int'($urandom_range(20, 100)), int'($urandom_range(20, 100)));
            for (int c = 0; c < 200; c++) begin
                rst_knob = ($urandom_range(299) == 0);
                cycle();
            end
            rst_knob = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/plab1_imul_mul_arbiter.md
Name: plab1_imul_mul_arbiter

Overview:
Shares one integer multiplier unit (latency-insensitive val/rdy, one request message in, one 32-bit product out) between two requesters.
- Request side: round-robin arbitration into the multiplier.
- Response side: products are returned in order to the requester that issued them, using a small tag queue that records grant order.
- Sits between two client ports (e.g. processor and accelerator) and a single multiplier instance.

Parameters:
- p_max_outstanding, 4, depth of tag queue = max requests granted but not yet answered; power of two, >= 2.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in0_val  input  1  requester 0 request valid
- in0_rdy  output  1  requester 0 request ready
- in0_msg  input  `PLAB1_IMUL_MULDIV_REQ_MSG_NBITS  requester 0 request message
- in1_val / in1_rdy / in1_msg  same as above, requester 1
- out0_val  output  1  response valid to requester 0
- out0_rdy  input  1  requester 0 response ready
- out0_msg  output  32  product to requester 0
- out1_val / out1_rdy / out1_msg  same as above, requester 1
- mul_req_val  output  1  request valid to multiplier
- mul_req_rdy  input  1  multiplier request ready
- mul_req_msg  output  `PLAB1_IMUL_MULDIV_REQ_MSG_NBITS  forwarded request message
- mul_resp_val  input  1  multiplier product valid
- mul_resp_rdy  output  1  ready to multiplier
- mul_resp_msg  input  32  product
- stat_grants0  output  16  count of grants to requester 0
- stat_grants1  output  16  count of grants to requester 1

Behaviour:
- State:
  - prio register: 1 bit; 0 means requester 0 has priority.
  - tag queue: p_max_outstanding x 1-bit entries, with head/tail pointers and a count.
- Reset (synchronous):
  - prio = 0; tag queue empty; stat counters = 0.
  - While reset is high, every *_val and *_rdy output is forced to 0.
- Request path (combinational in the current cycle):
  - can_issue = mul_req_rdy && !queue_full, where queue_full is the registered count == p_max_outstanding.
  - Grant rule:
    - Both val: grant goes to the prio requester.
    - One val: grant goes to that requester.
  - mul_req_val = can_issue && (in0_val || in1_val).
  - mul_req_msg = message of the granted requester.
  - inK_rdy = can_issue && grant==K. The non-granted requester sees rdy=0.
  - On a request transfer (mul_req_val && mul_req_rdy):
    - enqueue K at the tail;
    - prio <= ~K (requester K loses priority);
    - stat_grantsK += 1.
  - No transfer: prio holds.
- Response path (combinational):
  - head = tag at the queue head.
  - outK_val = mul_resp_val && !queue_empty && head==K.
  - outK_msg = mul_resp_msg for both K (the data is shared; only val is steered).
  - mul_resp_rdy = !queue_empty && out[head]_rdy.
  - On a response transfer: dequeue.
- Simultaneous enqueue and dequeue in one cycle: count unchanged; pointers both advance, wrapping modulo p_max_outstanding.
- Queue full: no new grants. A dequeue in the same cycle does not bypass to allow a grant (full is registered).
- mul_resp_val with an empty queue: mul_resp_rdy = 0, and an assertion fires (not-expected error).
- Latency: zero cycles added on either path. Throughput is one request and one response per cycle.
- Stat counters wrap from 0xFFFF to 0.
- Reset asserted mid-operation: queue is cleared and outstanding products are dropped. The environment must reset the multiplier in the same cycle.
- Assertions, checked when not in reset:
  - in*_val, out*_rdy, mul_req_rdy and mul_resp_val are never X.
  - At most one of in0_rdy/in1_rdy is high.

Optional Feature:
- Macro: PLAB1_IMUL_MUL_ARBITER_STATS_EN.
- Defined: stat_grants0/1 counters are implemented as described, and the line trace appends both counts.
- Undefined: the counter registers are not instantiated and stat_grants0/1 are tied to 16'd0. All other behaviour is identical.

Decomposition:
- Shared package (plab1-imul-msgs.v): the request-message width macros, plus a new `PLAB1_IMUL_ARB_TAG_NBITS (1) constant.
- Sub-module plab1_imul_tag_queue:
  - parameterized-depth 1-bit in-order FIFO;
  - enq_val/enq_rdy, deq_val/deq_rdy handshakes;
  - full/empty derived from a registered count.
- Arbiter top: prio register, grant muxing, response steering, stats.

Test Plan:
- Single requester 0, a=3, b=4, multiplier always ready → out0_msg=12, out0_val pulses once, out1_val never high.
- Both requesters hold valid every cycle (req0 a=2,b=5; req1 a=7,b=6) → grants alternate 0,1,0,1; responses 10,42,10,42 return to the matching ports in order; stat_grants0 = stat_grants1 after an even number of grants.
- Multiplier holds mul_resp_val=0 while requester 0 issues 5 requests with p_max_outstanding=4 → exactly 4 grants, then in0_rdy=0 until the first response is accepted.
- Head tag is 1 and out1_rdy=0 while out0_rdy=1 → mul_resp_rdy=0, no dequeue, out0_val=0; the response is delivered once out1_rdy rises.
- Reset asserted with 3 requests outstanding → next cycle queue empty, prio=0, all val/rdy outputs 0; a fresh request from requester 1 (a=0xFFFFFFFF, b=2) returns 0xFFFFFFFE on out1.
- Macro undefined, 10 grants → stat_grants0/1 read 0. Macro defined → the counts equal the grants per requester.
